fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Read-domain consumer of AsynchronousFIFO.
- Pops words through the FIFO's rinc/rempty/rdata interface and re-presents them on a registered valid/ready stream for downstream logic in the rclk domain.
- Holds words in a 2-entry buffer, so rinc never depends combinationally on out_ready, while still sustaining 1 word/cycle.

Parameters:
- DSIZE, 8, data width; matches the FIFO's DSIZE.
- CNTW, 16, width of the delivered-word counter (optional feature only).

Ports:
- rclk  in  1  read-domain clock.
- rrst_n  in  1  asynchronous active-low reset.
- rdata  in  DSIZE  FIFO read data. First-word fall-through: valid whenever rempty=0.
- rempty  in  1  FIFO empty flag, already synchronous to rclk.
- rinc  out  1  FIFO pop strobe. One word is popped per rclk edge while rinc=1.
- flush  in  1  synchronous clear of the internal buffer.
- out_data  out  DSIZE  stream data; the head of the buffer.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready from downstream.
- occ  out  2  buffer occupancy, 0..2, for debug.
- rd_count  out  CNTW  words delivered (only with FIFO_RD_CNT_EN).

Behaviour:
- Clock and reset: single clock rclk. Reset rrst_n is asynchronous assert, active-low; release is synchronous to rclk.
- Reset values: occ=0, out_valid=0, out_data=0, rd_count=0. rinc=0 while rrst_n=0.
- Buffer storage: two registers, HEAD and TAIL, plus an occupancy state machine with states EMPTY(0), ONE(1), TWO(2).
- Pop rule: rinc = !rempty && occ!=TWO && !flush && rrst_n.
  - rinc is purely a function of registered state and inputs; it never depends on out_ready.
- push = rinc, which captures rdata this cycle. pop = out_valid && out_ready.
- out_valid = (occ!=EMPTY). out_data = HEAD.
- State transitions:
  - EMPTY: push → ONE, HEAD<=rdata.
  - ONE:
    - push && pop → ONE, HEAD<=rdata.
    - push && !pop → TWO, TAIL<=rdata.
    - !push && pop → EMPTY.
    - otherwise hold.
  - TWO: no push is possible.
    - pop → ONE, HEAD<=TAIL.
    - otherwise hold.
- Latency: a word visible on rdata with rempty=0 in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Throughput: steady state ONE with out_ready=1 and rempty=0 gives 1 word/cycle.
- Stall: out_valid && !out_ready holds out_data stable, with at most one further FIFO pop (into TAIL).
- Ordering: words leave in exactly the FIFO pop order. No duplication, no loss except on flush or reset.
- Flush:
  - flush=1 forces rinc=0 that cycle.
  - Next edge: occ→EMPTY and out_valid→0. Buffered words are discarded. A concurrent pop is still considered accepted by downstream.
  - rd_count still increments for that pop.
  - The FIFO itself is not drained.
- Boundary cases:
  - rempty rising while in ONE: no push; the word in HEAD remains valid until accepted.
  - out_ready high while EMPTY: no effect.
- Reset mid-operation: buffer contents are lost immediately and outputs return to reset values. The FIFO side is reset independently by its own rrst_n.

Optional Feature:
- Macro: FIFO_RD_CNT_EN.
- Defined:
  - rd_count increments by 1 on every pop (out_valid && out_ready).
  - Wraps modulo 2^CNTW.
  - Cleared only by reset, not by flush.
- Undefined:
  - rd_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Basic transfer: reset, FIFO model holds 0xA5,0x3C,0x7E, out_ready=1 → out_data sequence A5,3C,7E on 3 consecutive cycles starting 1 cycle after the first rinc. Then occ=0 and rinc=0.
- Backpressure: 5 words queued, out_ready=0 for 10 cycles → exactly 2 rinc pulses, occ=2, out_data frozen at word0. Releasing out_ready → all 5 words delivered in order, 1/cycle.
- Empty boundary: single word 0x11, out_ready=0 → occ=1, rinc never reasserts while rempty=1. Then out_ready=1 → word accepted, out_valid=0 next cycle.
- Flush: occ=2 holding 0x01,0x02, assert flush 1 cycle with rempty=0 → rinc=0 that cycle, occ=0 next cycle. The next delivered word is the FIFO's following entry 0x03.
- Async reset mid-stream: rrst_n pulled low between rclk edges while occ=2 → out_valid=0, occ=0, rinc=0 immediately, without waiting for a clock edge.
- FIFO_RD_CNT_EN with CNTW=4: deliver 18 words → rd_count=2 (wrap). Flush does not clear it; reset does.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-domain consumer of an asynchronous FIFO.
// Pops first-word-fall-through words via rinc/rempty/rdata and re-presents
// them on a registered valid/ready stream through a 2-entry skid buffer.
// rinc depends only on registered occupancy, rempty, flush and reset, so
// there is no combinational path from out_ready back to the FIFO.
//
// Optional feature macro: FIFO_RD_CNT_EN
//   defined   -> rd_count port present, counts accepted words (wraps, reset-only clear)
//   undefined -> rd_count port and counter absent
//
// state | meaning
// ------+---------------------------------------------------------
// EMPTY | no word buffered, out_valid low
// ONE   | HEAD holds the next word to present, TAIL unused
// TWO   | HEAD presented, TAIL holds the following word; no FIFO pop
module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int CNTW  = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic [DSIZE-1:0] rdata,
   input  logic             rempty,
   output logic             rinc,
   input  logic             flush,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       occ
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNTW-1:0]  rd_count
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic             push;
   logic             pop;

   // Pop strobe and stream handshake, derived from registered state only
   always_comb begin
      rinc      = !rempty && (state_q != TWO) && !flush && rrst_n;
      push      = rinc;
      out_valid = (state_q != EMPTY);
      pop       = out_valid && out_ready;
      out_data  = head_q;
      occ       = state_q;
   end

   // Occupancy next-state and buffer data movement
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         // Buffered words are dropped; the FIFO itself keeps its contents.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  state_d = ONE;
                  head_d  = rdata;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_d = rdata;
               end else if (push) begin
                  state_d = TWO;
                  tail_d  = rdata;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (pop) begin
                  state_d = ONE;
                  head_d  = tail_q;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   // State and buffer registers
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

`ifdef FIFO_RD_CNT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;

   // Delivered-word count; a pop coinciding with flush still counts
   always_comb begin
      cnt_d = cnt_q + CNTW'(pop);
   end

   // Counter register, cleared by reset only
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign rd_count = cnt_q;
`endif

endmodule
